// File: rtl/ysyx_25040111_axi_rslave_if.sv
// ysyx_25040111_axi_rslave_if: AXI4 read address (AR) and read data (R) channel bundle
interface ysyx_25040111_axi_rslave_if;
    logic        arready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    modport master (
        input  arready, rvalid, rdata, rresp, rlast, rid,
        output arvalid, araddr, arid, arlen, arsize, arburst, rready
    );
    modport slave (
        output arready, rvalid, rdata, rresp, rlast, rid,
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready
    );
endinterface

// File: rtl/ysyx_25040111_axi_rslave.sv
// ysyx_25040111_axi_rslave: AXI4 read-only responder serving single/burst reads from a synchronous word memory
module ysyx_25040111_axi_rslave #(
    parameter logic [3:0]  REGION = 4'ha,
    parameter int unsigned AW     = 24
) (
    input  logic                      clock,
    input  logic                      reset,
    ysyx_25040111_axi_rslave_if.slave s,
    output logic                      mem_ren,
    output logic [AW-1:0]             mem_addr,
    input  logic [31:0]               mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, CAP, RESP} state_t;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, rdata_q, rdata_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  len_q, len_d, beat_q, beat_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d, err_q, err_d;
    logic [31:0] inc, mask, next_addr;
    logic        last, bad_wrap;
    assign inc  = 32'd1 << size_q;
    assign mask = ((32'(len_q) + 32'd1) << size_q) - 32'd1;
    // FIXED holds, WRAP steps inside the window aligned to the total burst size, INCR steps freely
    assign next_addr = burst_q == 2'b00 ? addr_q
                     : burst_q == 2'b10 ? (addr_q & ~mask) | ((addr_q + inc) & mask)
                     : addr_q + inc;
    assign last     = beat_q == len_q;
    assign bad_wrap = s.arburst == 2'b10 && !(s.arlen inside {8'd1, 8'd3, 8'd7, 8'd15});
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        id_d    = id_q;
        len_d   = len_q;
        beat_d  = beat_q;
        size_d  = size_q;
        burst_d = burst_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (s.arvalid) begin
                addr_d  = s.araddr;
                id_d    = s.arid;
                len_d   = s.arlen;
                size_d  = s.arsize;
                burst_d = s.arburst;
                beat_d  = '0;
                rdata_d = '0;
                err_d   = s.araddr[31:28] != REGION ? DECERR
                        : (s.arsize > 3'd2 || s.arburst == 2'b11 || bad_wrap) ? SLVERR : OKAY;
                state_d = err_d == OKAY ? REQ : RESP;
            end
            REQ: state_d = CAP;
            CAP: begin
                rdata_d = mem_rdata;
                state_d = RESP;
            end
            RESP: if (s.rready) begin
                state_d = last ? IDLE : err_q == OKAY ? REQ : RESP;
                beat_d  = last ? beat_q : beat_q + 8'd1;
                addr_d  = last ? addr_q : next_addr;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
            id_q    <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            id_q    <= id_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            err_q   <= err_d;
        end
    end
    assign s.arready = state_q == IDLE;
    assign s.rvalid  = state_q == RESP;
    assign s.rlast   = state_q == RESP && last;
    assign s.rresp   = err_q;
    assign s.rid     = id_q;
    assign s.rdata   = rdata_q;
    assign mem_ren   = state_q == REQ;
    assign mem_addr  = addr_q[AW+1:2];
endmodule

// File: tb/tb_ysyx_25040111_axi_rslave.sv
// tb_ysyx_25040111_axi_rslave: directed AR/R bursts checked by a scoreboard of expected beats and memory addresses
module tb_ysyx_25040111_axi_rslave;
    logic        clock = 1'b0, reset = 1'b0;
    logic        mem_ren;
    logic [23:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    int          n_chk = 0, n_fail = 0;
    logic [38:0] rq[$];
    logic [23:0] mq[$];
    ysyx_25040111_axi_rslave_if bus();
    ysyx_25040111_axi_rslave dut (
        .clock(clock), .reset(reset), .s(bus),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );
    always #5 clock = ~clock;
    function automatic logic [31:0] memval(logic [23:0] a);
        return a == 24'd4 ? 32'h1234_5678 : {8'hc5, a};
    endfunction
    always @(posedge clock) if (mem_ren) mem_rdata <= memval(mem_addr);
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic fail_now(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got event/timeout, expected none", name);
    endtask
    task automatic exp_beat(logic [31:0] d, logic [1:0] r, logic l, logic [3:0] id);
        rq.push_back({d, r, l, id});
    endtask
    // monitor: every memory strobe and every R handshake pops one expectation
    always @(negedge clock) if (!reset) begin
        if (mem_ren) begin
            if (mq.size() == 0) fail_now("mem_ren_unexpected");
            else chk("mem_addr", 64'(mem_addr), 64'(mq.pop_front()));
        end
        if (bus.rvalid && bus.rready) begin
            if (rq.size() == 0) fail_now("rbeat_unexpected");
            else chk("rbeat", 64'({bus.rdata, bus.rresp, bus.rlast, bus.rid}), 64'(rq.pop_front()));
        end
    end
    task automatic ar(logic [31:0] a, logic [3:0] id, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
        int t = 0;
        @(posedge clock);
        #1;
        bus.arvalid = 1'b1;
        bus.araddr  = a;
        bus.arid    = id;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        do begin @(negedge clock); t++; end while (!bus.arready && t < 100);
        if (!bus.arready) fail_now("ar_timeout");
        @(posedge clock);
        #1 bus.arvalid = 1'b0;
    endtask
    task automatic take(int stall);
        int t = 0;
        logic [31:0] d;
        logic l;
        do begin @(negedge clock); t++; end while (!bus.rvalid && t < 100);
        if (!bus.rvalid) fail_now("rvalid_timeout");
        d = bus.rdata;
        l = bus.rlast;
        repeat (stall) begin
            @(negedge clock);
            chk("hold_valid", 64'(bus.rvalid), 64'd1);
            chk("hold_data", 64'(bus.rdata), 64'(d));
            chk("hold_last", 64'(bus.rlast), 64'd0);
        end
        @(posedge clock);
        #1 bus.rready = 1'b1;
        @(posedge clock);
        #1 bus.rready = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int t;
        bus.arvalid = 1'b0;
        bus.araddr  = '0;
        bus.arid    = '0;
        bus.arlen   = '0;
        bus.arsize  = '0;
        bus.arburst = '0;
        bus.rready  = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_arready", 64'(bus.arready), 64'd1);
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_rlast", 64'(bus.rlast), 64'd0);
        chk("rst_rresp", 64'(bus.rresp), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        chk("rst_rid", 64'(bus.rid), 64'd0);
        chk("rst_mem_ren", 64'(mem_ren), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        // single beat with exact latency
        mq.push_back(24'h4);
        exp_beat(32'h1234_5678, 2'b00, 1'b1, 4'd1);
        ar(32'ha000_0010, 4'd1, 8'd0, 3'd2, 2'b01);
        @(negedge clock);
        chk("t1_mem_ren_cyc1", 64'(mem_ren), 64'd1);
        chk("t1_arready_busy", 64'(bus.arready), 64'd0);
        @(negedge clock);
        chk("t1_rvalid_cyc2", 64'(bus.rvalid), 64'd0);
        @(negedge clock);
        chk("t1_rvalid_cyc3", 64'(bus.rvalid), 64'd1);
        take(0);
        @(negedge clock);
        chk("t1_arready_after", 64'(bus.arready), 64'd1);
        // INCR len 3 with a stall on beat 1
        for (int i = 0; i < 4; i++) mq.push_back(24'h40 + 24'(i));
        exp_beat(32'hc500_0040, 2'b00, 1'b0, 4'd5);
        exp_beat(32'hc500_0041, 2'b00, 1'b0, 4'd5);
        exp_beat(32'hc500_0042, 2'b00, 1'b0, 4'd5);
        exp_beat(32'hc500_0043, 2'b00, 1'b1, 4'd5);
        ar(32'ha000_0100, 4'd5, 8'd3, 3'd2, 2'b01);
        take(0);
        take(2);
        take(0);
        take(0);
        // WRAP len 3 crossing the 16-byte window
        mq.push_back(24'h0e);
        mq.push_back(24'h0f);
        mq.push_back(24'h0c);
        mq.push_back(24'h0d);
        exp_beat(32'hc500_000e, 2'b00, 1'b0, 4'd2);
        exp_beat(32'hc500_000f, 2'b00, 1'b0, 4'd2);
        exp_beat(32'hc500_000c, 2'b00, 1'b0, 4'd2);
        exp_beat(32'hc500_000d, 2'b00, 1'b1, 4'd2);
        ar(32'ha000_0038, 4'd2, 8'd3, 3'd2, 2'b10);
        repeat (4) take(0);
        // WRAP with illegal length
        exp_beat(32'h0, 2'b10, 1'b0, 4'd3);
        exp_beat(32'h0, 2'b10, 1'b0, 4'd3);
        exp_beat(32'h0, 2'b10, 1'b1, 4'd3);
        ar(32'ha000_0038, 4'd3, 8'd2, 3'd2, 2'b10);
        repeat (3) take(0);
        // FIXED len 2
        repeat (3) mq.push_back(24'h08);
        exp_beat(32'hc500_0008, 2'b00, 1'b0, 4'd4);
        exp_beat(32'hc500_0008, 2'b00, 1'b0, 4'd4);
        exp_beat(32'hc500_0008, 2'b00, 1'b1, 4'd4);
        ar(32'ha000_0020, 4'd4, 8'd2, 3'd2, 2'b00);
        repeat (3) take(0);
        // oversize beat
        exp_beat(32'h0, 2'b10, 1'b1, 4'd9);
        ar(32'ha000_0000, 4'd9, 8'd0, 3'd3, 2'b01);
        take(0);
        // foreign region
        exp_beat(32'h0, 2'b11, 1'b0, 4'd6);
        exp_beat(32'h0, 2'b11, 1'b1, 4'd6);
        ar(32'h3000_0000, 4'd6, 8'd1, 3'd2, 2'b01);
        take(0);
        take(0);
        // async reset in the middle of beat 3
        for (int i = 0; i < 4; i++) mq.push_back(24'h80 + 24'(i));
        exp_beat(32'hc500_0080, 2'b00, 1'b0, 4'd7);
        exp_beat(32'hc500_0081, 2'b00, 1'b0, 4'd7);
        exp_beat(32'hc500_0082, 2'b00, 1'b0, 4'd7);
        ar(32'ha000_0200, 4'd7, 8'd7, 3'd2, 2'b01);
        repeat (3) take(0);
        t = 0;
        do begin @(negedge clock); t++; end while (!bus.rvalid && t < 100);
        chk("t6_beat3_valid", 64'(bus.rvalid), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("t6_rvalid_async", 64'(bus.rvalid), 64'd0);
        chk("t6_rlast_async", 64'(bus.rlast), 64'd0);
        chk("t6_mq_drained", 64'(mq.size()), 64'd0);
        chk("t6_rq_drained", 64'(rq.size()), 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("t6_arready_release", 64'(bus.arready), 64'd1);
        repeat (3) @(negedge clock);
        chk("t6_no_more_beats", 64'(bus.rvalid), 64'd0);
        mq.push_back(24'h4);
        exp_beat(32'h1234_5678, 2'b00, 1'b1, 4'd8);
        ar(32'ha000_0010, 4'd8, 8'd0, 3'd2, 2'b01);
        take(0);
        repeat (3) @(negedge clock);
        chk("end_rq_empty", 64'(rq.size()), 64'd0);
        chk("end_mq_empty", 64'(mq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
